arb8_sched: RTL and testbench
=============================

// Module: arb8_sched
// PURPOSE
//   8-requester arbiter that shares a single resource port, e.g. a shared
//   bus or execution unit. The winner is selected by a priority-encode
//   search: highest index wins, as in the team's 8:3 priority encoder.
//   The grant is registered and held until the owner drops its request or
//   the hold limit expires. Every grant ends with a one-cycle turnaround gap.
//   Supports fixed-priority and round-robin modes.
// PARAMETERS
//   HOLD_MAX  16  max consecutive grant cycles per ownership; legal 2..256
//   RR        0   0 = fixed priority (bit 7 highest); 1 = round-robin
// PORTS
//   clk        in   1  single clock; all state updates on rising edge
//   rst        in   1  asynchronous, active-high reset
//   req        in   8  request vector; bit i = requester i wants the resource
//   gnt        out  8  one-hot grant; all-zero when no owner
//   gnt_id     out  3  index of current owner; valid only when gnt_valid=1
//   gnt_valid  out  1  1 while a grant is held (== |gnt)
//   timeout    out  1  1-cycle pulse: grant was forcibly revoked at HOLD_MAX
// BEHAVIOUR
//   Reset (async, immediate, also mid-grant):
//   - state=IDLE; gnt=0, gnt_id=0, gnt_valid=0, timeout=0
//   - last_id=0, hold_cnt=0
//   All outputs are registered. No combinational path from req to gnt.
//   Winner search:
//   - RR=0: highest set bit of req.
//   - RR=1: search downward starting at (last_id-1) mod 8, wrapping, so
//     last_id has lowest priority.
//   - last_id=0 after reset, so the first RR search equals fixed priority.
//   States:
//   - IDLE: at each edge, if req!=0 -> GRANT with the winner latched into
//     gnt/gnt_id; otherwise stay IDLE.
//     Latency: req visible at edge N -> gnt high in the cycle after N.
//   - GRANT: hold_cnt=0 in the first grant cycle. At each edge:
//     a) req[gnt_id]=0 -> GAP, no timeout (wins over b if both true).
//     b) else if hold_cnt==HOLD_MAX-1 -> GAP, timeout=1 during the GAP cycle.
//     c) else hold_cnt++, stay in GRANT.
//     Maximum ownership is exactly HOLD_MAX cycles.
//     Requests on other bits never preempt the current owner.
//     On leaving GRANT: last_id <= gnt_id, hold_cnt <= 0.
//   - GAP: exactly 1 cycle with gnt=0, gnt_valid=0.
//     At the edge: if req!=0 -> GRANT with a new winner; else -> IDLE.
//     In RR=0 a revoked owner may regain the grant immediately after GAP.
//   Output rules:
//   - timeout is high only in GAP cycles that follow a forced revoke;
//     0 in all other cycles.
//   - gnt is always one-hot or zero; gnt_id is held at its last value
//     while gnt_valid=0.
//   hold_cnt width is $clog2(HOLD_MAX); it never wraps because the limit
//   check precedes the increment.
// TESTING
//   1 Assert rst mid-GRANT -> gnt, gnt_valid, timeout drop to 0 in the same
//     cycle without a clock edge; after release, req=0 -> stays IDLE.
//   2 RR=0, req=8'h24 -> gnt=8'h20, gnt_id=5 one cycle later. Drop req[5]
//     -> 1 gap cycle -> gnt=8'h04, gnt_id=2.
//   3 RR=0, HOLD_MAX=4, req=8'h08 held -> gnt=8'h08 for 4 cycles, then a
//     gap with timeout=1, then gnt=8'h08 again; pattern repeats.
//   4 RR=1, HOLD_MAX=4, req=8'h09 held -> grant order 3,0,3,0.
//     timeout pulses once per gap.
//   5 RR=1, req=8'hFF, each owner drops its request for one cycle after
//     1 grant cycle -> gnt_id sequence 7,6,5,4,3,2,1,0,7.
//   6 HOLD_MAX=4, owner drops req exactly in its 4th grant cycle
//     -> GAP with timeout=0 (release beats timeout).

Source files
------------

// File: rtl/arb8_if.sv
// arb8_if: request/grant bundle between the requesters and arb8_sched.
//   req        requesters -> arbiter, one bit per requester
//   gnt        one-hot grant, zero when no owner
//   gnt_id     index of the current (or most recent) owner
//   gnt_valid  high while a grant is held
//   timeout    one-cycle pulse in the gap after a forced revoke
// master = requester side, slave = arbiter side.
interface arb8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req,
    output gnt, gnt_id, gnt_valid, timeout
  );
endinterface

// File: rtl/arb8_sched.sv
// arb8_sched: 8-requester arbiter for one shared resource.
// The winner is the highest-priority set request bit. It holds the grant
// until it drops its request or HOLD_MAX cycles elapse, and every grant is
// followed by one idle gap cycle.
//   HOLD_MAX  max consecutive grant cycles per ownership (2..256)
//   RR        0 = fixed priority (bit 7 highest), 1 = round-robin
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   arb8_if slave: req in; gnt, gnt_id, gnt_valid, timeout out
// All outputs come from flops; req never reaches gnt combinationally.
module arb8_sched #(
  parameter int unsigned HOLD_MAX = 16,
  parameter bit          RR       = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  arb8_if.slave bus
);

  localparam int unsigned       CW        = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0]     HOLD_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    gnt_q, gnt_d;
  logic [2:0]    gnt_id_q, gnt_id_d;
  logic          timeout_q, timeout_d;
  logic [2:0]    last_id_q, last_id_d;
  logic [CW-1:0] hold_q, hold_d;

  // Winner search: scan downward from a start index with 3-bit wraparound.
  // Round-robin starts just below the previous owner so it ranks last.
  logic [2:0] start_id;
  logic [2:0] idx;
  logic [2:0] win_id;
  logic       win_found;

  always_comb begin
    start_id  = RR ? (last_id_q - 3'd1) : 3'd7;
    idx       = '0;
    win_id    = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = start_id - 3'(k);
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    timeout_d = 1'b0;
    last_id_d = last_id_q;
    hold_d    = hold_q;

    unique case (state_q)
      S_IDLE, S_GAP: begin
        gnt_d = '0;
        if (win_found) begin
          state_d  = S_GRANT;
          gnt_d    = 8'b1 << win_id;
          gnt_id_d = win_id;
          hold_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        // Release is checked first so a drop in the final cycle is not a timeout.
        if (!bus.req[gnt_id_q] || (hold_q == HOLD_LAST)) begin
          state_d   = S_GAP;
          gnt_d     = '0;
          timeout_d = bus.req[gnt_id_q];
          last_id_d = gnt_id_q;
          hold_d    = '0;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      timeout_q <= 1'b0;
      last_id_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      timeout_q <= timeout_d;
      last_id_q <= last_id_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_arb8_sched.sv
module tb_arb8_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb8_if if_fp ();
  arb8_if if_rr ();
  arb8_if if_df ();

  arb8_sched #(.HOLD_MAX(4),  .RR(1'b0)) u_fp (.clk(clk), .rst(rst), .bus(if_fp.slave));
  arb8_sched #(.HOLD_MAX(4),  .RR(1'b1)) u_rr (.clk(clk), .rst(rst), .bus(if_rr.slave));
  arb8_sched #(.HOLD_MAX(16), .RR(1'b0)) u_df (.clk(clk), .rst(rst), .bus(if_df.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one owner index (or -1), a tenure count and the last
  // owner per instance. Gap and idle are both "no owner".
  int          m_hold  [3] = '{4, 4, 16};
  bit          m_rr    [3] = '{1'b0, 1'b1, 1'b0};
  int          m_owner [3] = '{-1, -1, -1};
  int          m_ten   [3] = '{0, 0, 0};
  int          m_last  [3] = '{0, 0, 0};
  int          m_id    [3] = '{0, 0, 0};
  bit          m_to    [3] = '{1'b0, 1'b0, 1'b0};

  logic [7:0]  req_a   [3];
  logic [7:0]  gnt_a   [3];
  logic [2:0]  id_a    [3];
  logic        val_a   [3];
  logic        to_a    [3];

  assign req_a[0] = if_fp.req;  assign gnt_a[0] = if_fp.gnt;
  assign req_a[1] = if_rr.req;  assign gnt_a[1] = if_rr.gnt;
  assign req_a[2] = if_df.req;  assign gnt_a[2] = if_df.gnt;
  assign id_a[0]  = if_fp.gnt_id; assign val_a[0] = if_fp.gnt_valid; assign to_a[0] = if_fp.timeout;
  assign id_a[1]  = if_rr.gnt_id; assign val_a[1] = if_rr.gnt_valid; assign to_a[1] = if_rr.timeout;
  assign id_a[2]  = if_df.gnt_id; assign val_a[2] = if_df.gnt_valid; assign to_a[2] = if_df.timeout;

  // Priority as a distance: the requester with the smallest distance wins.
  function automatic int pick(input logic [7:0] r, input int last, input bit rr);
    int best = -1;
    int bd   = 99;
    int d;
    for (int i = 0; i < 8; i++) begin
      if (r[i]) begin
        d = rr ? ((last - 1 - i + 16) % 8) : (7 - i);
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_owner[k] = -1; m_ten[k] = 0; m_last[k] = 0; m_id[k] = 0; m_to[k] = 1'b0;
      end else if (m_owner[k] < 0) begin
        m_to[k] = 1'b0;
        if (req_a[k] != 8'h00) begin
          m_owner[k] = pick(req_a[k], m_last[k], m_rr[k]);
          m_id[k]    = m_owner[k];
          m_ten[k]   = 1;
        end
      end else if (!req_a[k][m_owner[k]]) begin
        m_last[k] = m_owner[k]; m_owner[k] = -1; m_to[k] = 1'b0;
      end else if (m_ten[k] == m_hold[k]) begin
        m_last[k] = m_owner[k]; m_owner[k] = -1; m_to[k] = 1'b1;
      end else begin
        m_ten[k]++; m_to[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model%0d_gnt", k), 32'(gnt_a[k]),
          (m_owner[k] >= 0) ? (32'h1 << m_owner[k]) : 32'h0);
      chk($sformatf("model%0d_id", k), 32'(id_a[k]), 32'(m_id[k]));
      chk($sformatf("model%0d_valid", k), 32'(val_a[k]), 32'(m_owner[k] >= 0));
      chk($sformatf("model%0d_timeout", k), 32'(to_a[k]), 32'(m_to[k]));
    end
  end

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t vec [21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if_fp.req = '0; if_rr.req = '0; if_df.req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int         seen;
    int         tos;
    logic       prev_v;
    logic [2:0] order [4];
    logic [2:0] exp_order [4];
    logic [2:0] exp5;
    bit         got;

    // Fixed priority, HOLD_MAX=4: handoff 5->2, timeout loop, release in 4th cycle.
    vec[0]  = '{8'h24, 8'h20, 3'd5, 1'b1, 1'b0};
    vec[1]  = '{8'h04, 8'h00, 3'd5, 1'b0, 1'b0};
    vec[2]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
    vec[3]  = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
    vec[4]  = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
    vec[5]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[6]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[7]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[8]  = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[9]  = '{8'h08, 8'h00, 3'd3, 1'b0, 1'b1};
    vec[10] = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[11] = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[12] = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[13] = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[14] = '{8'h08, 8'h00, 3'd3, 1'b0, 1'b1};
    vec[15] = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[16] = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[17] = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[18] = '{8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[19] = '{8'h00, 8'h00, 3'd3, 1'b0, 1'b0};
    vec[20] = '{8'h00, 8'h00, 3'd3, 1'b0, 1'b0};

    if_fp.req = '0; if_rr.req = '0; if_df.req = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(if_fp.gnt), 32'h0);
    chk("reset_id", 32'(if_rr.gnt_id), 32'h0);
    chk("reset_valid", 32'(if_df.gnt_valid), 32'h0);
    chk("reset_timeout", 32'(if_fp.timeout), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      if_fp.req = vec[i].req;
      tick();
      chk($sformatf("vec%0d_gnt", i), 32'(if_fp.gnt), 32'(vec[i].gnt));
      chk($sformatf("vec%0d_id", i), 32'(if_fp.gnt_id), 32'(vec[i].id));
      chk($sformatf("vec%0d_valid", i), 32'(if_fp.gnt_valid), 32'(vec[i].valid));
      chk($sformatf("vec%0d_timeout", i), 32'(if_fp.timeout), 32'(vec[i].to));
    end

    // Round-robin alternation under timeouts: 3,0,3,0 with one pulse per gap.
    do_reset();
    exp_order = '{3'd3, 3'd0, 3'd3, 3'd0};
    seen = 0; tos = 0; prev_v = 1'b0;
    if_rr.req = 8'h09;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (if_rr.gnt_valid && !prev_v && seen < 4) begin
        order[seen] = if_rr.gnt_id;
        seen++;
      end
      if (if_rr.timeout) tos++;
      prev_v = if_rr.gnt_valid;
    end
    chk("rr_grant_count", 32'(seen), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < seen) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    chk("rr_timeout_pulses", 32'(tos), 32'd4);

    // Round-robin sweep: each owner drops after one grant cycle.
    do_reset();
    if_rr.req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      got = 1'b0;
      for (int w = 0; w < 5 && !got; w++) begin
        tick();
        got = if_rr.gnt_valid;
      end
      if (!got) begin
        chk($sformatf("rr_sweep_wait%0d", n), 32'(got), 32'd1);
        break;
      end
      exp5 = 3'(7 - (n % 8));
      chk($sformatf("rr_sweep%0d", n), 32'(if_rr.gnt_id), 32'(exp5));
      if_rr.req = 8'hFF & ~if_rr.gnt;
      tick();
      chk($sformatf("rr_sweep_gap%0d", n), 32'(if_rr.gnt_valid), 32'd0);
      if_rr.req = 8'hFF;
    end

    // Asynchronous reset mid-grant and mid-timeout-gap.
    do_reset();
    if_fp.req = 8'h08;
    if_df.req = 8'h80;
    repeat (5) tick();
    chk("pre_rst_timeout", 32'(if_fp.timeout), 32'd1);
    chk("pre_rst_valid", 32'(if_df.gnt_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(if_df.gnt), 32'h0);
    chk("async_rst_valid", 32'(if_df.gnt_valid), 32'd0);
    chk("async_rst_timeout", 32'(if_fp.timeout), 32'd0);
    if_fp.req = '0; if_df.req = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post_rst_idle%0d", c), 32'(if_df.gnt_valid), 32'd0);
    end

    // Randomized traffic, compared each cycle by the model checker.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(3) == 0) if_fp.req = 8'($urandom) & 8'($urandom);
      if ($urandom_range(3) == 0) if_rr.req = 8'($urandom);
      if ($urandom_range(7) == 0) if_df.req = 8'($urandom) & 8'($urandom);
      if ($urandom_range(199) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1);
  end

endmodule
